// File: rtl/ca_run_ctrl.sv
// ca_run_ctrl: run sequencer for the cellular-automaton array.
// Latches a rule, seed, generation count and boundary mode on start. It loads the seed,
// lets the array evolve for the requested number of generations, then freezes it and
// reports the final row with a one-cycle done pulse.
// Optional feature macro: CA_FIXPOINT_EN (stop early when the row stops changing).
module ca_run_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned GEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rule_in,
  input  logic [WIDTH-1:0] seed,
  input  logic [GEN_W-1:0] gens,
  input  logic [1:0]       bmode,
  input  logic [WIDTH-1:0] ca_out,
  output logic [7:0]       ca_rule,
  output logic [WIDTH-1:0] ca_state,
  output logic             ca_set_state,
  output logic             ca_left,
  output logic             ca_right,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [GEN_W-1:0] gen_count,
  output logic             fixpoint
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] seed_q;
  logic [GEN_W-1:0] gens_q;
  logic [1:0]       bmode_q;
  logic [GEN_W-1:0] cnt_q;
  logic [GEN_W-1:0] cnt_inc;
  logic             last_gen;

  assign cnt_inc  = cnt_q + 1'b1;
  assign last_gen = (cnt_inc == gens_q);

`ifdef CA_FIXPOINT_EN
  logic [WIDTH-1:0] prev_q;
  logic             fp_hit_q;
  logic             stalled;
  // The first RUN cycle has no valid previous row, so it never counts as stalled.
  assign stalled = (cnt_q != '0) && (ca_out == prev_q);
`endif

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: state_d = (gens_q == '0) ? HOLD : RUN;
      RUN: begin
        if (last_gen) state_d = HOLD;
`ifdef CA_FIXPOINT_EN
        else if (stalled) state_d = HOLD;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Array control: every state except RUN reloads the array, which freezes it.
  always_comb begin
    busy         = (state_q != IDLE);
    ca_set_state = (state_q != RUN);
    case (state_q)
      IDLE:    ca_state = result;
      LOAD:    ca_state = seed_q;
      default: ca_state = ca_out;
    endcase
  end

  // Boundary drive from the latched mode; mode 11 behaves as zeros.
  always_comb begin
    case (bmode_q)
      2'b01: begin
        ca_left  = 1'b1;
        ca_right = 1'b1;
      end
      2'b10: begin
        ca_left  = ca_out[WIDTH-1];
        ca_right = ca_out[0];
      end
      default: begin
        ca_left  = 1'b0;
        ca_right = 1'b0;
      end
    endcase
  end

  // Sequencer state, run parameters and the reported results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      gens_q    <= '0;
      bmode_q   <= 2'b00;
      cnt_q     <= '0;
      ca_rule   <= 8'h00;
      result    <= '0;
      gen_count <= '0;
      done      <= 1'b0;
`ifdef CA_FIXPOINT_EN
      prev_q    <= '0;
      fp_hit_q  <= 1'b0;
      fixpoint  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      done    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ca_rule  <= rule_in;
            seed_q   <= seed;
            gens_q   <= gens;
            bmode_q  <= bmode;
            cnt_q    <= '0;
`ifdef CA_FIXPOINT_EN
            fp_hit_q <= 1'b0;
            fixpoint <= 1'b0;
`endif
          end
        end
        RUN: begin
          cnt_q <= cnt_inc;
`ifdef CA_FIXPOINT_EN
          prev_q <= ca_out;
          if (stalled && !last_gen) fp_hit_q <= 1'b1;
`endif
        end
        HOLD: begin
          result    <= ca_out;
          gen_count <= cnt_q;
          done      <= 1'b1;
`ifdef CA_FIXPOINT_EN
          fixpoint  <= fp_hit_q;
`endif
        end
        default: ;
      endcase
    end
  end

`ifndef CA_FIXPOINT_EN
  assign fixpoint = 1'b0;
`endif

endmodule

// File: doc/ca_run_ctrl.md
# ca_run_ctrl

Sequencer for the 8-cell cellular-automaton array. It latches a rule, seed, generation count and boundary mode on a start pulse, then loads the seed into the array. It lets the array evolve for exactly the requested number of generations, freezes it, and returns the final row with a one-cycle done pulse. It sits between the host/register interface and the array, and owns every array control input (rule, state, set_state, left, right).

## Interface
Parameters:
- WIDTH, 8, number of cells in the driven array
- GEN_W, 8, width of generation count and counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request a run; sampled only in IDLE
- rule_in  in  8  Wolfram rule number for the run
- seed  in  WIDTH  initial row
- gens  in  GEN_W  generations to run (0 allowed)
- bmode  in  2  boundary mode: 00 zeros, 01 ones, 10 wrap, 11 treated as 00
- ca_out  in  WIDTH  current row from the array
- ca_rule  out  8  rule to the array (registered)
- ca_state  out  WIDTH  load value to the array
- ca_set_state  out  1  array load strobe
- ca_left  out  1  left boundary for cell 0
- ca_right  out  1  right boundary for cell WIDTH-1
- busy  out  1  high in LOAD, RUN, HOLD
- done  out  1  one-cycle completion pulse (registered)
- result  out  WIDTH  final row, held until the next run completes
- gen_count  out  GEN_W  generations applied in the last run
- fixpoint  out  1  last run ended early on a fixed point

## Operation
- The array advances one generation every edge unless set_state is high; set_state=1 loads ca_state. The controller freezes the array by reloading it.
- States:
  - IDLE: ca_set_state=1, ca_state=result, so the array holds the last result. start=1 latches rule_in, seed, gens and bmode; gen counter clears; next state is LOAD.
  - LOAD: ca_set_state=1, ca_state=latched seed. Next state is RUN, or HOLD if gens=0.
  - RUN: ca_set_state=0; the counter increments each edge. When counter+1 == gens, next state is HOLD.
  - HOLD: ca_set_state=1, ca_state=ca_out (freeze). At the edge: result<=ca_out, gen_count<=counter, done<=1, next state is IDLE.
- Boundaries, driven in every state:
  - zeros: ca_left=ca_right=0
  - ones: ca_left=ca_right=1
  - wrap: ca_left=ca_out[WIDTH-1], ca_right=ca_out[0]
- start while busy is ignored; it is not queued.
- Reset (async, any state): state IDLE; ca_rule=0, result=0, gen_count=0, done=0, busy=0, fixpoint=0, latched bmode=00; ca_set_state=1, ca_state=0 (array cleared on the next edge).
- gen counter is GEN_W bits and never wraps, since it stops at gens ≤ 2^GEN_W-1.

## Timing
- start sampled at edge e0 → LOAD during cycle e0..e1 → seed in array after e1.
- After N RUN edges the array holds generation N → HOLD for 1 cycle → done high in the cycle after edge e(N+2). Total latency from start edge to done-high is N+3 edges (3 for N=0).
- Same-edge case: done=1 coincides with IDLE, so start can be sampled on that same edge; back-to-back runs have no dead cycle.
- ca_rule changes only on the start-sampling edge.
- busy falls on the same edge that done rises.

## Configuration
- CA_FIXPOINT_EN defined:
  - Register prev<=ca_out on each RUN edge.
  - From the second RUN cycle onward, if ca_out==prev, go to HOLD immediately. That edge is still counted in gen_count.
  - fixpoint<=1 at HOLD exit; it is cleared on the next start.
- CA_FIXPOINT_EN undefined: no prev register and no early exit; fixpoint is tied 0.

## Test plan
- Zeros boundary: rule 0x5A, bmode 00, seed 0x10, gens 1 → done 4 edges after start, result 0x28, gen_count 1.
- Wrap vs zeros: rule 0x5A, seed 0x01, gens 1 → result 0x82 with bmode 10; result 0x02 with bmode 00.
- gens=0: seed 0xA5, any rule → result 0xA5, gen_count 0, done 3 edges after start; array never sees set_state=0.
- Freeze and ignored start: after a run gives result 0x28, hold 20 idle cycles → ca_out stays 0x28. A start pulsed while busy=1 → no extra done pulse.
- Fixed point: rule 0x00, seed 0xFF, gens 10.
  - With CA_FIXPOINT_EN: result 0x00, gen_count 3, fixpoint 1, done 6 edges after start.
  - Without the macro: gen_count 10, fixpoint 0, done 13 edges after start.
- Reset mid-RUN at gen 3 of 10: immediately busy=0, ca_set_state=1, ca_state=0, result=0. The next edge clears the array to 0x00. No done pulse occurs, and a new start runs normally.
